// File: rtl/accumulator.sv
// Accumulator register: captures the ALU result on a load strobe and exposes
// combinational status flags (zero, negative, parity) derived from the held
// value, plus a sticky "has been loaded since reset" indicator.
module accumulator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alout,
  input  logic             idac,
  output logic [WIDTH-1:0] acout,
  output logic             ac_zero,
  output logic             ac_neg,
  output logic             ac_parity,
  output logic             ac_valid
);

  // Accumulator contents: cleared asynchronously, loaded verbatim on idac.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acout <= '0;
    end else if (idac) begin
      acout <= alout;
    end
  end

  // Sticky valid flag: set by the first load after reset, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ac_valid <= 1'b0;
    end else if (idac) begin
      ac_valid <= 1'b1;
    end
  end

  // Status flags look only at the registered value, never at alout, so they
  // stay stable between edges whatever the ALU is doing.
  // NOTE: every output of this block is assigned unconditionally, so no
  // latch can be inferred.
  always_comb begin
    ac_zero   = (acout == '0);
    ac_neg    = acout[WIDTH-1];
    ac_parity = ^acout;
  end

endmodule

// File: tb/tb_accumulator.sv
// Directed testbench for the accumulator: hand-computed vectors covering
// reset, load, hold, reset dominance, no-edge stability and flag boundaries.
module tb_accumulator;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] alout;
  logic             idac;
  logic [WIDTH-1:0] acout;
  logic             ac_zero;
  logic             ac_neg;
  logic             ac_parity;
  logic             ac_valid;

  int n_compared;
  int n_mismatched;

  accumulator #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .alout     (alout),
    .idac      (idac),
    .acout     (acout),
    .ac_zero   (ac_zero),
    .ac_neg    (ac_neg),
    .ac_parity (ac_parity),
    .ac_valid  (ac_valid)
  );

  // One full clock period: rising edge mid-period, ends with clk low so the
  // following checks sample away from the active edge.
  task automatic pulse();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed,
                       input logic [7:0] expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Check every output against one expected state.
  task automatic check_all(input string tag, input logic [7:0] exp_ac,
                           input logic exp_zero, input logic exp_neg,
                           input logic exp_par, input logic exp_valid);
    check({tag, ".acout"},     acout,              exp_ac);
    check({tag, ".ac_zero"},   {7'b0, ac_zero},    {7'b0, exp_zero});
    check({tag, ".ac_neg"},    {7'b0, ac_neg},     {7'b0, exp_neg});
    check({tag, ".ac_parity"}, {7'b0, ac_parity},  {7'b0, exp_par});
    check({tag, ".ac_valid"},  {7'b0, ac_valid},   {7'b0, exp_valid});
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    clk   = 1'b0;
    rst   = 1'b0;
    idac  = 1'b0;
    alout = 8'h00;
    #2;

    // Reset state at power-up.
    check_all("reset_init", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset dominates load: edges with idac high while rst low do nothing.
    idac  = 1'b1;
    alout = 8'hFF;
    pulse();
    pulse();
    check_all("reset_dominance", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Release reset with idac low: an edge without load leaves state alone.
    idac = 1'b0;
    rst  = 1'b1;
    #2;
    pulse();
    check_all("post_reset_noload", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Load A5 (four ones -> even parity, MSB set).
    idac  = 1'b1;
    alout = 8'hA5;
    pulse();
    check_all("load_a5", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset with no clock edge clears immediately.
    idac = 1'b0;
    rst  = 1'b0;
    #1;
    check_all("async_reset", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Load 81 (two ones -> even parity, MSB set).
    rst = 1'b1;
    #2;
    idac  = 1'b1;
    alout = 8'h81;
    pulse();
    check_all("load_81", 8'h81, 1'b0, 1'b1, 1'b0, 1'b1);

    // Hold for three edges with idac low and a different alout.
    idac  = 1'b0;
    alout = 8'h3C;
    pulse();
    pulse();
    pulse();
    check_all("hold_3_edges", 8'h81, 1'b0, 1'b1, 1'b0, 1'b1);

    // idac pulsed high between edges only: no load.
    idac  = 1'b1;
    alout = 8'h55;
    #2;
    idac  = 1'b0;
    alout = 8'hAA;
    pulse();
    check("glitch_idac.acout", acout, 8'h81);

    // Clock held high: alout/idac activity causes no change.
    #5 clk = 1'b1;
    #1;
    check("clk_high.acout", acout, 8'h81);
    idac  = 1'b1;
    alout = 8'h12;
    #2;
    check("clk_high_12.acout", acout, 8'h81);
    alout = 8'h34;
    #2;
    alout = 8'h56;
    #2;
    check_all("clk_high_56", 8'h81, 1'b0, 1'b1, 1'b0, 1'b1);
    idac = 1'b0;
    #2 clk = 1'b0;
    #1;
    check("clk_fall.acout", acout, 8'h81);

    // Parity boundary: 07 has three ones.
    idac  = 1'b1;
    alout = 8'h07;
    pulse();
    check_all("load_07", 8'h07, 1'b0, 1'b0, 1'b1, 1'b1);

    // Zero after load: valid stays set.
    alout = 8'h00;
    pulse();
    check_all("load_00", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

    // Sign boundary: 7F positive with odd parity, 80 negative with odd parity.
    alout = 8'h7F;
    pulse();
    check_all("load_7f", 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1);
    alout = 8'h80;
    pulse();
    check_all("load_80", 8'h80, 1'b0, 1'b1, 1'b1, 1'b1);

    // Mid-operation reset, then first load lands on the first edge after release.
    idac = 1'b0;
    rst  = 1'b0;
    #1;
    check_all("mid_reset", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    rst   = 1'b1;
    #2;
    idac  = 1'b1;
    alout = 8'h3C;
    pulse();
    check_all("first_load_after_reset", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
